// File: rtl/cpu_pkg.sv
// Shared definitions for the basic-computer control path: opcodes, sequencer states, timing indices.
// Pure constants and types; no logic, no latency.
package cpu_pkg;

    localparam int unsigned OP_LDA = 0;
    localparam int unsigned OP_STA = 1;
    localparam int unsigned OP_ADD = 2;
    localparam int unsigned OP_JMP = 3;
    localparam int unsigned OP_HLT = 7;

    localparam int unsigned T0 = 0;
    localparam int unsigned T1 = 1;
    localparam int unsigned T2 = 2;
    localparam int unsigned T3 = 3;

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/control_sequencer.sv
// Instruction-cycle sequencer: walks fetch/exec rounds off the one-hot T counter and issues micro-op enables.
// Micro-ops are combinational in the current T step; state and the sticky T error register on clk.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     T,
    input  logic [OPW-1:0] ir_op,
    input  logic           ir_ind,
    input  logic           start,
    output logic           clr,
    output logic           ar_ld_pc,
    output logic           ar_ld_ir,
    output logic           ar_ld_mem,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           ir_ld,
    output logic           pc_inc,
    output logic           pc_ld_ar,
    output logic           dr_ld,
    output logic           ac_ld,
    output logic           ac_add,
    output logic           halted,
    output logic           t_err
);

    state_t state, state_nxt;
    logic   bad_t;
    logic   is_lda, is_sta, is_add, is_jmp, is_hlt;

    assign bad_t  = !$onehot(T);
    assign is_lda = (ir_op == OPW'(OP_LDA));
    assign is_sta = (ir_op == OPW'(OP_STA));
    assign is_add = (ir_op == OPW'(OP_ADD));
    assign is_jmp = (ir_op == OPW'(OP_JMP));
    assign is_hlt = (ir_op == OPW'(OP_HLT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_HALT;
            t_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != S_HALT && bad_t)
                t_err <= 1'b1;
        end
    end

    assign halted = (state == S_HALT);

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        ar_ld_pc  = 1'b0;
        ar_ld_ir  = 1'b0;
        ar_ld_mem = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        ir_ld     = 1'b0;
        pc_inc    = 1'b0;
        pc_ld_ar  = 1'b0;
        dr_ld     = 1'b0;
        ac_ld     = 1'b0;
        ac_add    = 1'b0;
        case (state)
            S_HALT: begin
                clr = 1'b1;
                if (start)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (bad_t) begin
                    clr = 1'b1;
                end else if (T[T0]) begin
                    ar_ld_pc = 1'b1;
                end else if (T[T1]) begin
                    mem_rd = 1'b1;
                    ir_ld  = 1'b1;
                    pc_inc = 1'b1;
                end else if (T[T2]) begin
                    if (is_hlt) begin
                        clr       = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        ar_ld_ir = 1'b1;
                    end
                end else begin
                    // Indirect fetch rides on T3; the counter wraps into EXEC T0 unaided.
                    ar_ld_mem = ir_ind;
                    mem_rd    = ir_ind;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                clr       = 1'b1;
                state_nxt = S_FETCH;
                if (!bad_t && T[T0]) begin
                    if (is_lda || is_add) begin
                        clr       = 1'b0;
                        state_nxt = S_EXEC;
                        mem_rd    = 1'b1;
                        dr_ld     = 1'b1;
                    end else begin
                        mem_wr   = is_sta;
                        pc_ld_ar = is_jmp;
                    end
                end else if (!bad_t && T[T1]) begin
                    ac_ld  = is_lda;
                    ac_add = is_add;
                end
            end
            default: begin
                clr       = 1'b1;
                state_nxt = S_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench: per-instruction step tables predict every cycle's outputs; a negedge monitor compares.
// Includes a behavioural T0-T3 ring counter driven by the sequencer's clr, with an override to inject bad T.
module tb_control_sequencer;

    localparam logic [13:0] M_CLR   = 14'h2000;
    localparam logic [13:0] M_ARPC  = 14'h1000;
    localparam logic [13:0] M_ARIR  = 14'h0800;
    localparam logic [13:0] M_ARMEM = 14'h0400;
    localparam logic [13:0] M_RD    = 14'h0200;
    localparam logic [13:0] M_WR    = 14'h0100;
    localparam logic [13:0] M_IRLD  = 14'h0080;
    localparam logic [13:0] M_PCINC = 14'h0040;
    localparam logic [13:0] M_PCLD  = 14'h0020;
    localparam logic [13:0] M_DRLD  = 14'h0010;
    localparam logic [13:0] M_ACLD  = 14'h0008;
    localparam logic [13:0] M_ACADD = 14'h0004;
    localparam logic [13:0] M_HALT  = 14'h0002;
    localparam logic [13:0] M_TERR  = 14'h0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] T, t_cnt, t_force;
    logic       force_en = 1'b0;
    logic [2:0] ir_op = 3'd0;
    logic       ir_ind = 1'b0;
    logic       start = 1'b0;
    logic       clr, ar_ld_pc, ar_ld_ir, ar_ld_mem, mem_rd, mem_wr, ir_ld, pc_inc;
    logic       pc_ld_ar, dr_ld, ac_ld, ac_add, halted, t_err;
    logic [13:0] act;

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad = 0;
    logic        terr_m = 1'b0;
    logic        halt_m = 1'b1;
    logic [3:0]  bad_pats [5];

    control_sequencer #(.OPW(3)) dut (
        .clk(clk), .rst(rst), .T(T), .ir_op(ir_op), .ir_ind(ir_ind), .start(start),
        .clr(clr), .ar_ld_pc(ar_ld_pc), .ar_ld_ir(ar_ld_ir), .ar_ld_mem(ar_ld_mem),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_ld(ir_ld), .pc_inc(pc_inc),
        .pc_ld_ar(pc_ld_ar), .dr_ld(dr_ld), .ac_ld(ac_ld), .ac_add(ac_add),
        .halted(halted), .t_err(t_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)      t_cnt <= 4'b0001;
        else if (clr) t_cnt <= 4'b0001;
        else          t_cnt <= {t_cnt[2:0], t_cnt[3]};
    end
    assign T = force_en ? t_force : t_cnt;

    assign act = {clr, ar_ld_pc, ar_ld_ir, ar_ld_mem, mem_rd, mem_wr, ir_ld, pc_inc,
                  pc_ld_ar, dr_ld, ac_ld, ac_add, halted, t_err};

    always @(negedge clk) begin
        logic [13:0] e;
        string       nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got %b want %b (t=%0t)", nm, act, e, $time);
            end
        end
    end

    task automatic step(input logic [13:0] e, input string nm);
        exp_q.push_back(e | (terr_m ? M_TERR : 14'h0));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start  = 1'b0;
            ir_op  = 3'($urandom);
            ir_ind = 1'($urandom);
            step(M_CLR | M_HALT, "halt_idle");
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step(M_CLR | M_HALT, "halt_start");
        start  = 1'b0;
        halt_m = 1'b0;
    endtask

    // abort_at: step index where T is forced to bad_pat; rst_at: step index where reset hits.
    task automatic run_instr(input int op, input bit ind, input int abort_at,
                             input logic [3:0] bad_pat, input int rst_at);
        logic [13:0] s [6];
        int          n;
        s[0] = M_ARPC;
        s[1] = M_RD | M_IRLD | M_PCINC;
        s[2] = (op == 7) ? M_CLR : M_ARIR;
        s[3] = ind ? (M_RD | M_ARMEM) : 14'h0;
        s[4] = M_CLR;
        s[5] = 14'h0;
        n    = (op == 7) ? 3 : 5;
        case (op)
            0: begin s[4] = M_RD | M_DRLD; s[5] = M_ACLD | M_CLR;  n = 6; end
            2: begin s[4] = M_RD | M_DRLD; s[5] = M_ACADD | M_CLR; n = 6; end
            1: s[4] = M_WR | M_CLR;
            3: s[4] = M_PCLD | M_CLR;
            default: ;
        endcase
        if (halt_m) begin
            idle($urandom_range(0, 3));
            do_start();
        end
        for (int i = 0; i < n; i++) begin
            start = 1'($urandom);
            if (i < 2) begin
                ir_op  = 3'($urandom);
                ir_ind = 1'($urandom);
            end else begin
                ir_op  = 3'(op);
                ir_ind = ind;
            end
            if (i == abort_at) begin
                force_en = 1'b1;
                t_force  = bad_pat;
                step(M_CLR, $sformatf("bad_t_op%0d_s%0d", op, i));
                force_en = 1'b0;
                terr_m   = 1'b1;
                return;
            end
            if (i == rst_at) begin
                rst    = 1'b1;
                terr_m = 1'b0;
                halt_m = 1'b1;
                step(M_CLR | M_HALT, $sformatf("rst_mid_op%0d_s%0d", op, i));
                rst = 1'b0;
                return;
            end
            step(s[i], $sformatf("op%0d_ind%0d_s%0d", op, ind, i));
        end
        if (op == 7) halt_m = 1'b1;
    endtask

    initial begin
        int op, ab, rs;
        bad_pats[0] = 4'b0000;
        bad_pats[1] = 4'b0011;
        bad_pats[2] = 4'b1111;
        bad_pats[3] = 4'b0101;
        bad_pats[4] = 4'b1100;

        @(posedge clk);
        #1;
        step(M_CLR | M_HALT, "reset_state");
        rst = 1'b0;
        idle(10);

        run_instr(0, 1'b0, -1, 4'b0, -1);
        run_instr(1, 1'b1, -1, 4'b0, -1);
        run_instr(2, 1'b0, -1, 4'b0, -1);
        run_instr(3, 1'b1, -1, 4'b0, -1);
        run_instr(7, 1'b0, -1, 4'b0, -1);
        idle(4);
        run_instr(5, 1'b0, -1, 4'b0, -1);

        run_instr(2, 1'b0, 1, 4'b0011, -1);
        run_instr(0, 1'b1, -1, 4'b0, -1);
        run_instr(4, 1'b0, 4, 4'b0000, -1);
        run_instr(7, 1'b1, -1, 4'b0, -1);
        run_instr(6, 1'b0, -1, 4'b0, -1);
        run_instr(0, 1'b0, -1, 4'b0, 4);
        run_instr(2, 1'b1, -1, 4'b0, -1);

        for (int k = 0; k < 300; k++) begin
            op = int'($urandom_range(0, 7));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
            rs = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_instr(op, 1'($urandom), ab, bad_pats[$urandom_range(0, 4)], rs);
        end
        run_instr(7, 1'b0, -1, 4'b0, -1);
        idle(2);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Control sequencer for the basic-computer datapath. It consumes the one-hot timing signals T[3:0] from the timing counter and drives that counter's synchronous `clr`. It steps each instruction through fetch, decode and execute rounds and issues one-cycle micro-operation enables to the register and memory logic. It owns the instruction-cycle state, so instructions can span more than one T0–T3 round.

## Interface
Parameters:
- OPW, 3, opcode field width (`ir_op`)

Ports (clock and reset first):
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- T  in  4  one-hot timing step from timing counter (T[0]=T0)
- ir_op  in  OPW  opcode field of IR, valid from T2 of the fetch round
- ir_ind  in  1  indirect-address bit of IR, valid from T2 of the fetch round
- start  in  1  leave HALT (sampled only in HALT)
- clr  out  1  synchronous clear to timing counter
- ar_ld_pc  out  1  AR <- PC
- ar_ld_ir  out  1  AR <- IR address field
- ar_ld_mem  out  1  AR <- M[AR]
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe (M[AR] <- AC)
- ir_ld  out  1  IR <- M[AR]
- pc_inc  out  1  PC <- PC+1
- pc_ld_ar  out  1  PC <- AR
- dr_ld  out  1  DR <- M[AR]
- ac_ld  out  1  AC <- DR
- ac_add  out  1  AC <- AC+DR
- halted  out  1  state is HALT
- t_err  out  1  sticky: T was not one-hot outside HALT

## Operation
- Opcodes: 0 LDA, 1 STA, 2 ADD, 3 JMP, 7 HLT. Opcodes 4–6 are NOP.
- States: HALT, FETCH, EXEC. Registered state. All outputs except `halted` and `t_err` are combinational from state, T, `ir_op` and `ir_ind`.
- HALT:
  - `clr`=1, all micro-ops 0.
  - `start`=1 → FETCH. The counter is held at T0, so FETCH begins at T0.
- FETCH:
  - T0: `ar_ld_pc`.
  - T1: `mem_rd`, `ir_ld`, `pc_inc`.
  - T2: if `ir_op`=7, assert `clr` and go to HALT. Otherwise assert `ar_ld_ir`.
  - T3: if `ir_ind`=1, assert `mem_rd` and `ar_ld_mem`. Go to EXEC; the counter wraps to T0 with no `clr`.
- EXEC:
  - T0, LDA/ADD: `mem_rd` and `dr_ld`.
  - T0, STA: `mem_wr`, `clr`, go to FETCH.
  - T0, JMP: `pc_ld_ar`, `clr`, go to FETCH.
  - T0, NOP: `clr`, go to FETCH.
  - T1, LDA: `ac_ld`, `clr`, go to FETCH.
  - T1, ADD: `ac_add`, `clr`, go to FETCH.
- Each micro-op is asserted for exactly one cycle per step. No two AR-load enables are ever high together.
- One-hot check: outside HALT, if T is zero or has more than one bit set:
  - set `t_err`, suppress all micro-ops, assert `clr`, go to FETCH.
  - `t_err` is cleared only by `rst`.

## Timing
- Reset (asynchronous): state=HALT, `t_err`=0. Therefore `halted`=1, `clr`=1, all micro-ops 0, starting in the same cycle.
- `clr` is seen by the counter at the next edge, so T=T0 on the cycle after any `clr` assertion.
- Latency from `start`:
  - first `ar_ld_pc` on the cycle after `start` is sampled;
  - `ir_ld` follows 1 cycle later.
- Cycles per instruction, fetch through last execute step:
  - STA/JMP/NOP: 5
  - LDA/ADD: 6
  - HLT: 3, then HALT
  - indirect addressing adds no cycles (it uses T3).
- `start` while not in HALT is ignored.
- `rst` mid-instruction aborts immediately. Partially applied datapath effects are not undone.
- `ir_op`/`ir_ind` are ignored at T0/T1 of FETCH, because IR is stale then.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants OP_LDA, OP_STA, OP_ADD, OP_JMP, OP_HLT
  - state encoding (HALT/FETCH/EXEC)
  - T index constants T0–T3
- Single module, no sub-module. Opcode decode is inline combinational logic.
- The timing counter stays a separate instance. The sequencer drives its `clr` and reads its `T`.

## Test plan
- Reset then idle → `halted`=1, `clr`=1 and all micro-ops 0 for 10 cycles. `start` pulse → `ar_ld_pc` at next T0, `ir_ld`+`pc_inc` at T1.
- LDA direct (`ir_op`=0, `ir_ind`=0) → 6-cycle sequence ending in `ac_ld`+`clr` at EXEC T1. Next cycle T=T0 with `ar_ld_pc`.
- STA indirect (`ir_op`=1, `ir_ind`=1) → `ar_ld_mem`+`mem_rd` at FETCH T3, then `mem_wr`+`clr` at EXEC T0. Total 5 cycles.
- Back-to-back ADD, JMP, HLT → `ac_add` once, `pc_ld_ar` once, then `clr` at FETCH T2 and `halted`=1. A later `start` resumes fetch.
- Force T=4'b0011 during FETCH → `t_err`=1, no micro-ops that cycle, `clr`=1. `t_err` stays 1 until `rst`.
- Assert `rst` during EXEC T0 of LDA → same-cycle `halted`=1, `dr_ld`/`mem_rd` drop to 0, `clr`=1.
